lcd1604_bus_receiver: RTL and testbench

- Receiving end of the HD44780-style 8-bit LCD bus (rs, rw, enable, data) driven by the team's LCD controllers.
- Captures each strobe on the falling edge of enable and decodes configuration commands and data writes.
- Keeps a shadow DDRAM and the display-mode registers, so the system can read back what the panel shows (debug mirror, self-check, UART dump).
- Sits on the same board clock as the controller; enable is a slow divided strobe and is treated as asynchronous.

---
 rtl/lcd1604_bus_receiver.sv | 241 ++++++++++++++++++++++++
 tb/tb_lcd1604_bus_receiver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lcd1604_bus_receiver.sv
// HD44780-style 8-bit LCD bus receiver with shadow DDRAM; optional LCD_RX_TIMING_CHECK_EN checks enable-high width.
// Latency: cmd_valid/data_valid SYNC_STAGES+1 clk after enable falls; rd_data 1 clk after rd_addr.
// Backpressure: none on the bus; strobes arriving during a clear are dropped and flagged in overrun.
`timescale 1ns/1ps
module lcd1604_bus_receiver #(
  parameter int DATA_BITS   = 8,
  parameter int DDRAM_DEPTH = 80,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_E_HIGH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rs,
  input  logic                 rw,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] data,
  input  logic [6:0]           rd_addr,
  output logic [7:0]           rd_data,
  output logic                 cmd_valid,
  output logic                 data_valid,
  output logic [7:0]           last_byte,
  output logic [6:0]           cursor_addr,
  output logic                 display_on,
  output logic                 cursor_on,
  output logic                 blink_on,
  output logic                 two_line,
  output logic                 mode_8bit,
  output logic                 inc_dir,
  output logic                 busy,
  output logic                 overrun,
  output logic                 addr_err,
  output logic                 timing_err
);

  if (DATA_BITS != 8 || SYNC_STAGES < 2 || MIN_E_HIGH < 1) begin : g_param_check
    $error("lcd1604_bus_receiver: unsupported parameter set");
  end

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  logic [SYNC_STAGES-1:0] en_sync, rs_sync, rw_sync;
  logic [DATA_BITS-1:0]   dat_sync [SYNC_STAGES];
  logic                   en_prev;
  logic                   en_s, rs_s, rw_s, en_fall, stb;
  logic [DATA_BITS-1:0]   dat_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_sync <= '0;
      rs_sync <= '0;
      rw_sync <= '0;
      en_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) dat_sync[i] <= '0;
    end else begin
      en_sync <= {en_sync[SYNC_STAGES-2:0], enable};
      rs_sync <= {rs_sync[SYNC_STAGES-2:0], rs};
      rw_sync <= {rw_sync[SYNC_STAGES-2:0], rw};
      en_prev <= en_s;
      dat_sync[0] <= data;
      for (int i = 1; i < SYNC_STAGES; i++) dat_sync[i] <= dat_sync[i-1];
    end
  end

  assign en_s    = en_sync[SYNC_STAGES-1];
  assign rs_s    = rs_sync[SYNC_STAGES-1];
  assign rw_s    = rw_sync[SYNC_STAGES-1];
  assign dat_s   = dat_sync[SYNC_STAGES-1];
  assign en_fall = en_prev & ~en_s;
  assign stb     = en_fall & ~rw_s;

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else    r = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    return r;
  endfunction

  function automatic logic addr_ok(input logic [6:0] a);
    return (a < 7'h28) || ((a >= 7'h40) && (a < 7'h68));
  endfunction

  // Line 2 (0x40..0x67) packs directly after line 1's 40 entries.
  function automatic logic [6:0] ddram_idx(input logic [6:0] a);
    return (a < 7'h28) ? a : a - 7'd24;
  endfunction

  state_t     state, state_nxt;
  logic [6:0] clr_idx, clr_idx_nxt, ac_nxt;
  logic [7:0] last_nxt;
  logic       cmd_nxt, dat_nxt, disp_nxt, cur_nxt, blink_nxt;
  logic       two_nxt, m8_nxt, inc_nxt, ovr_nxt, aerr_nxt;
  logic       wr_en;
  logic [6:0] wr_idx;
  logic [7:0] wr_dat;
  logic [7:0] mem [DDRAM_DEPTH];

  assign busy = (state == ST_CLEAR);

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    ac_nxt      = cursor_addr;
    last_nxt    = last_byte;
    cmd_nxt     = 1'b0;
    dat_nxt     = 1'b0;
    disp_nxt    = display_on;
    cur_nxt     = cursor_on;
    blink_nxt   = blink_on;
    two_nxt     = two_line;
    m8_nxt      = mode_8bit;
    inc_nxt     = inc_dir;
    ovr_nxt     = overrun;
    aerr_nxt    = addr_err;
    wr_en       = 1'b0;
    wr_idx      = '0;
    wr_dat      = '0;
    case (state)
      ST_IDLE: begin
        if (stb) begin
          last_nxt = dat_s;
          if (rs_s) begin
            wr_en   = 1'b1;
            wr_idx  = ddram_idx(cursor_addr);
            wr_dat  = dat_s;
            ac_nxt  = ac_step(cursor_addr, inc_dir);
            dat_nxt = 1'b1;
          end else begin
            cmd_nxt = 1'b1;
            casez (dat_s)
              8'b1???_????: begin
                if (addr_ok(dat_s[6:0])) ac_nxt = dat_s[6:0];
                else begin
                  ac_nxt   = 7'h00;
                  aerr_nxt = 1'b1;
                end
              end
              8'b01??_????: aerr_nxt = 1'b1;
              8'b001?_????: begin
                m8_nxt  = dat_s[4];
                two_nxt = dat_s[3];
              end
              8'b0001_????: if (!dat_s[3]) ac_nxt = ac_step(cursor_addr, dat_s[2]);
              8'b0000_1???: begin
                disp_nxt  = dat_s[2];
                cur_nxt   = dat_s[1];
                blink_nxt = dat_s[0];
              end
              8'b0000_01??: inc_nxt = dat_s[1];
              8'b0000_001?: ac_nxt = 7'h00;
              8'b0000_0001: begin
                state_nxt   = ST_CLEAR;
                clr_idx_nxt = '0;
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLEAR: begin
        wr_en  = 1'b1;
        wr_idx = clr_idx;
        wr_dat = 8'h20;
        if (stb && !rs_s && dat_s == 8'h01) begin
          clr_idx_nxt = '0;
          cmd_nxt     = 1'b1;
          last_nxt    = dat_s;
        end else begin
          if (clr_idx == 7'(DDRAM_DEPTH - 1)) begin
            state_nxt = ST_IDLE;
            ac_nxt    = 7'h00;
            inc_nxt   = 1'b1;
          end else begin
            clr_idx_nxt = clr_idx + 7'd1;
          end
          if (stb) ovr_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      clr_idx     <= '0;
      cursor_addr <= 7'h00;
      last_byte   <= 8'h00;
      cmd_valid   <= 1'b0;
      data_valid  <= 1'b0;
      display_on  <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      two_line    <= 1'b0;
      mode_8bit   <= 1'b1;
      inc_dir     <= 1'b1;
      overrun     <= 1'b0;
      addr_err    <= 1'b0;
      rd_data     <= 8'h00;
    end else begin
      state       <= state_nxt;
      clr_idx     <= clr_idx_nxt;
      cursor_addr <= ac_nxt;
      last_byte   <= last_nxt;
      cmd_valid   <= cmd_nxt;
      data_valid  <= dat_nxt;
      display_on  <= disp_nxt;
      cursor_on   <= cur_nxt;
      blink_on    <= blink_nxt;
      two_line    <= two_nxt;
      mode_8bit   <= m8_nxt;
      inc_dir     <= inc_nxt;
      overrun     <= ovr_nxt;
      addr_err    <= aerr_nxt;
      rd_data     <= addr_ok(rd_addr) ? mem[ddram_idx(rd_addr)] : 8'h00;
    end
  end

  // Shadow RAM has no reset so it maps onto plain block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_dat;
  end

`ifdef LCD_RX_TIMING_CHECK_EN
  localparam int HW = $clog2(MIN_E_HIGH + 1);
  logic [HW-1:0] hi_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_cnt     <= '0;
      timing_err <= 1'b0;
    end else begin
      if (!en_s) hi_cnt <= '0;
      else if (hi_cnt != HW'(MIN_E_HIGH)) hi_cnt <= hi_cnt + 1'b1;
      if (en_fall && (hi_cnt < HW'(MIN_E_HIGH))) timing_err <= 1'b1;
    end
  end
`else
  assign timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd1604_bus_receiver.sv
// Directed self-checking bench for lcd1604_bus_receiver.
`timescale 1ns/1ps
module tb_lcd1604_bus_receiver;

  logic       clk = 1'b0;
  logic       reset, rs, rw, enable;
  logic [7:0] data;
  logic [6:0] rd_addr;
  logic [7:0] rd_data, last_byte;
  logic [6:0] cursor_addr;
  logic       cmd_valid, data_valid, display_on, cursor_on, blink_on;
  logic       two_line, mode_8bit, inc_dir, busy, overrun, addr_err, timing_err;

  int checks = 0;
  int errors = 0;
  int cv_at, dv_at, bz_cnt, bad;
  logic [7:0] v;

  always #5 clk = ~clk;

  lcd1604_bus_receiver dut (
    .clk(clk), .reset(reset), .rs(rs), .rw(rw), .enable(enable), .data(data),
    .rd_addr(rd_addr), .rd_data(rd_data), .cmd_valid(cmd_valid), .data_valid(data_valid),
    .last_byte(last_byte), .cursor_addr(cursor_addr), .display_on(display_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .two_line(two_line), .mode_8bit(mode_8bit),
    .inc_dir(inc_dir), .busy(busy), .overrun(overrun), .addr_err(addr_err),
    .timing_err(timing_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one bus strobe, then records the cycle (1..6 after the fall) of any pulses.
  task automatic send(input logic rs_i, input logic rw_i, input logic [7:0] b, input int hi);
    @(posedge clk); #1;
    rs = rs_i; rw = rw_i; data = b; enable = 1'b1;
    repeat (hi) @(posedge clk);
    #1 enable = 1'b0;
    cv_at = 0; dv_at = 0; bz_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (cmd_valid && cv_at == 0) cv_at = i;
      if (data_valid && dv_at == 0) dv_at = i;
      if (busy) bz_cnt++;
    end
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] val);
    @(posedge clk); #1 rd_addr = a;
    @(posedge clk); #1 val = rd_data;
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 300; g++) begin
      @(posedge clk); #1;
      if (!busy) break;
      bz_cnt++;
    end
  endtask

  task automatic count_spaces(output int nbad);
    logic [7:0] r;
    nbad = 0;
    for (int i = 0; i < 80; i++) begin
      rd((i < 40) ? 7'(i) : 7'(i + 24), r);
      if (r !== 8'h20) nbad++;
    end
  endtask

  initial begin
    reset = 1'b0; rs = 1'b0; rw = 1'b0; enable = 1'b0; data = 8'h00; rd_addr = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cursor", cursor_addr, 7'h00);
    check("rst_inc_dir", inc_dir, 1'b1);
    check("rst_mode_8bit", mode_8bit, 1'b1);
    check("rst_flags", {display_on, cursor_on, blink_on, two_line, busy, overrun, addr_err, timing_err}, 8'h00);
    check("rst_pulses", {cmd_valid, data_valid}, 2'b00);
    check("rst_last_rd", {last_byte, rd_data}, 16'h0000);
    @(posedge clk); #1 reset = 1'b1;

    send(1'b0, 1'b0, 8'h38, 6);
    check("fs_cv_latency", cv_at, 3);
    check("fs_no_dv", dv_at, 0);
    check("fs_two_line", two_line, 1'b1);
    check("fs_mode_8bit", mode_8bit, 1'b1);
    send(1'b0, 1'b0, 8'h06, 6);
    check("em_inc_dir", inc_dir, 1'b1);
    send(1'b0, 1'b0, 8'h0C, 6);
    check("dc_flags", {display_on, cursor_on, blink_on}, 3'b100);
    send(1'b0, 1'b0, 8'h01, 6);
    check("clr_cv_latency", cv_at, 3);
    wait_idle();
    check("clr_busy_cycles", bz_cnt, 80);
    check("clr_busy_done", busy, 1'b0);
    check("clr_cursor", cursor_addr, 7'h00);
    count_spaces(bad);
    check("clr_all_spaces", bad, 0);

    send(1'b0, 1'b0, 8'hC0, 6);
    check("set_ac_40", cursor_addr, 7'h40);
    send(1'b1, 1'b0, 8'h41, 6);
    check("d41_dv_latency", dv_at, 3);
    check("d41_no_cv", cv_at, 0);
    send(1'b1, 1'b0, 8'h42, 6);
    check("d42_dv_latency", dv_at, 3);
    check("d42_cursor", cursor_addr, 7'h42);
    check("d42_last_byte", last_byte, 8'h42);
    rd(7'h40, v); check("rd_40", v, 8'h41);
    rd(7'h41, v); check("rd_41", v, 8'h42);

    send(1'b0, 1'b0, 8'hA7, 6);
    check("set_ac_27", cursor_addr, 7'h27);
    send(1'b1, 1'b0, 8'h5A, 6);
    check("wrap_27_40", cursor_addr, 7'h40);
    send(1'b0, 1'b0, 8'hE7, 6);
    send(1'b1, 1'b0, 8'h5B, 6);
    check("wrap_67_00", cursor_addr, 7'h00);
    rd(7'h27, v); check("rd_27", v, 8'h5A);
    rd(7'h67, v); check("rd_67", v, 8'h5B);
    check("no_addr_err_yet", addr_err, 1'b0);

    send(1'b0, 1'b0, 8'h14, 6);
    check("shift_right", cursor_addr, 7'h01);
    send(1'b0, 1'b0, 8'hB0, 6);
    check("bad_ac_err", addr_err, 1'b1);
    check("bad_ac_forced", cursor_addr, 7'h00);
    send(1'b0, 1'b0, 8'h85, 6);
    check("set_ac_05", cursor_addr, 7'h05);
    send(1'b0, 1'b0, 8'h40, 6);
    check("cgram_no_ac_change", cursor_addr, 7'h05);
    check("cgram_err_sticky", addr_err, 1'b1);
    check("cgram_last_byte", last_byte, 8'h40);
    send(1'b0, 1'b0, 8'h10, 6);
    check("shift_left", cursor_addr, 7'h04);
    send(1'b0, 1'b0, 8'h04, 6);
    check("em_dec", inc_dir, 1'b0);
    send(1'b1, 1'b0, 8'h61, 6);
    check("dec_write_ac", cursor_addr, 7'h03);
    rd(7'h04, v); check("rd_04", v, 8'h61);
    send(1'b0, 1'b0, 8'h06, 6);
    send(1'b0, 1'b0, 8'h80, 6);
    send(1'b0, 1'b0, 8'h10, 6);
    check("wrap_left_00_67", cursor_addr, 7'h67);
    rd(7'h30, v); check("rd_invalid", v, 8'h00);

    send(1'b1, 1'b1, 8'h77, 6);
    check("rw_no_pulse", {cv_at[3:0], dv_at[3:0]}, 8'h00);
    check("rw_cursor", cursor_addr, 7'h67);
    check("rw_last_byte", last_byte, 8'h10);
    rd(7'h67, v); check("rw_no_write", v, 8'h5B);

    check("ovr_before", overrun, 1'b0);
    send(1'b0, 1'b0, 8'h01, 6);
    repeat (4) @(posedge clk);
    send(1'b1, 1'b0, 8'h99, 6);
    check("ovr_no_dv", dv_at, 0);
    check("ovr_set", overrun, 1'b1);
    wait_idle();
    check("ovr_busy_done", busy, 1'b0);
    check("ovr_cursor", cursor_addr, 7'h00);
    count_spaces(bad);
    check("ovr_all_spaces", bad, 0);

    send(1'b1, 1'b0, 8'h7E, 2);
    check("short_dv", dv_at, 3);
    rd(7'h00, v); check("short_written", v, 8'h7E);
`ifdef LCD_RX_TIMING_CHECK_EN
    check("short_timing_err", timing_err, 1'b1);
`else
    check("timing_err_tied", timing_err, 1'b0);
`endif

    send(1'b0, 1'b0, 8'h85, 6);
    send(1'b0, 1'b0, 8'h01, 6);
    repeat (5) @(posedge clk);
    #1;
    check("midclr_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("midclr_rst_busy", busy, 1'b0);
    check("midclr_rst_cursor", cursor_addr, 7'h00);
    check("midclr_rst_sticky", {overrun, addr_err, display_on}, 3'b000);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
